candidate_accumulator: RTL and testbench
========================================

CANDIDATE_ACCUMULATOR -- requirements
Module: candidate_accumulator

Interface
REQ-001 SHALL have parameter LANES, default 4: result lanes per beat, range 2..16.
REQ-002 SHALL have parameter CNT_W, default 10: accumulator width, range 4..16.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a new count.
REQ-006 SHALL have port mode  input  2  count mode, sampled only on accepted start.
REQ-007 SHALL have port in_valid  input  1  beat qualifier.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid&in_ready.
REQ-009 SHALL have port in_data  input  LANES  result bits, lane 0 oldest.
REQ-010 SHALL have port in_cnt  input  $clog2(LANES+1)  valid lanes this beat, lanes 0..in_cnt-1; values above LANES are clamped to LANES.
REQ-011 SHALL have port in_last  input  1  marks final beat of the count.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port candidate  output  CNT_W  running/final count.
REQ-015 SHALL have port sat  output  1  sticky: accumulator saturated this count.
REQ-016 SHALL have port busy  output  1  high in ACCUM or DONE.

Function
REQ-017 SHALL implement FSM IDLE -> ACCUM on start; ACCUM -> DONE on accepted beat with in_last; DONE -> IDLE on out_valid&out_ready.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL, on start in IDLE, clear candidate, sat and pending bit, and latch mode.
REQ-020 SHALL drive in_ready=1 only in ACCUM; out_valid=1 only in DONE.
REQ-021 SHALL hold candidate stable in DONE and IDLE until next start.
REQ-022 SHALL update candidate the cycle after a beat is accepted (latency 1); candidate in DONE includes the last beat.
REQ-023 Mode 00 SHALL add popcount of valid lanes.
REQ-024 Modes 01/10 SHALL treat valid lanes as a continuous bit stream across beats, forming consecutive non-overlapping pairs; 01 adds 1 per pair with a&b, 10 adds 1 per pair with a^b.
REQ-025 SHALL hold an unpaired trailing bit in a pending register and pair it with lane 0 of the next valid bit, across beats with in_cnt=0.
REQ-026 SHALL discard a pending bit left at in_last without counting it.
REQ-027 Mode 11 SHALL add 1 per beat whose valid-lane popcount equals exactly 2.
REQ-028 SHALL compute increment at width $clog2(LANES+1) and add with saturation at 2^CNT_W-1; sat set on any clipped add, sticky until start.
REQ-029 SHALL treat a beat with in_cnt=0 as accepted and contributing 0 (in_last still honoured).

Reset
REQ-030 SHALL, on rst, asynchronously force state IDLE, candidate=0, sat=0, pending cleared, mode=00, in_ready=0, out_valid=0, busy=0.
REQ-031 SHALL abandon any count in progress on rst mid-ACCUM or mid-DONE; no partial result is presented.

Structure
REQ-032 SHALL place mode encoding (CM_ALL, CM_AND, CM_XOR, CM_TWO) and FSM state type in shared package cand_pkg.
REQ-033 SHALL instantiate one sub-module cand_popcount (parametrised LANES, masked by in_cnt) for modes 00 and 11.

Verification
REQ-034 Mode 00, LANES=4: beats 1011/cnt4, 0111/cnt3 last -> candidate=6 in DONE, out_valid held until out_ready.
REQ-035 Mode 01: beats 111/cnt3, 1/cnt1 last -> pairs (1,1),(1,1) -> candidate=2; pending spans beats.
REQ-036 Mode 10: beats 1/cnt1, 0/cnt1, 11/cnt2, 1/cnt1 last -> candidate=1, trailing bit discarded.
REQ-037 Mode 11: beats 0110/cnt4, 1110/cnt4, 0011/cnt2 last -> candidate=2.
REQ-038 CNT_W=4, mode 00, five beats of 1111/cnt4 -> candidate=15, sat=1; start clears both.
REQ-039 rst asserted mid-ACCUM after 2 beats -> next cycle IDLE, candidate=0, in_ready=0; start while busy ignored.

Source files
------------

// File: rtl/cand_pkg.sv
// Shared types for the candidate accumulator: count-mode encoding, FSM states
// and the per-pair hit rule used by the pairing modes.
package cand_pkg;

  typedef enum logic [1:0] {
    CM_ALL = 2'b00,
    CM_AND = 2'b01,
    CM_XOR = 2'b10,
    CM_TWO = 2'b11
  } cand_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } cand_state_e;

  function automatic logic pair_hit(input cand_mode_e m, input logic a, input logic b);
    logic hit;
    case (m)
      CM_AND:  hit = a & b;
      CM_XOR:  hit = a ^ b;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cand_popcount.sv
// Masked popcount of one beat: lanes 0..in_cnt-1 are valid, in_cnt clamped to LANES.
// Also exports the lane-valid mask so the pairing logic uses the same clamp.
module cand_popcount
  import cand_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] in_data,
  input  logic [CW-1:0]    in_cnt,
  output logic [LANES-1:0] lane_mask,
  output logic [CW-1:0]    pop
);

  localparam logic [CW-1:0] MAX_CNT = CW'(LANES);

  logic [CW-1:0] cnt_eff_s;

  // clamp the lane count, build the mask and add up the masked ones
  always_comb begin
    lane_mask = '0;
    pop       = '0;
    if (in_cnt > MAX_CNT) begin
      cnt_eff_s = MAX_CNT;
    end else begin
      cnt_eff_s = in_cnt;
    end
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = (CW'(i) < cnt_eff_s);
      if (lane_mask[i] && in_data[i]) begin
        pop = pop + CW'(1);
      end else begin
        pop = pop;
      end
    end
  end

endmodule

// File: rtl/candidate_accumulator.sv
// Counts "candidate" results over a framed sequence of beats in one of four
// modes, saturating at 2^CNT_W-1 with a sticky saturation flag.
module candidate_accumulator
  import cand_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0]             in_data,
  input  logic [$clog2(LANES+1)-1:0]   in_cnt,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             candidate,
  output logic                         sat,
  output logic                         busy
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CNT_W:0] CAP = {1'b0, {CNT_W{1'b1}}};

  cand_state_e      state_q, state_d;
  cand_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic             sat_q, sat_d;
  logic             pend_v_q, pend_v_d;
  logic             pend_b_q, pend_b_d;
  logic             in_ready_q, out_valid_q, busy_q;

  logic [LANES-1:0] lane_mask_s;
  logic [CW-1:0]    pop_s;
  logic [CW-1:0]    pair_inc_s;
  logic             pv_s, pb_s;
  logic [CW-1:0]    inc_s;
  logic [CNT_W:0]   sum_s;
  logic [CNT_W-1:0] cand_sat_s;
  logic             clip_s;

  cand_popcount #(.LANES(LANES), .CW(CW)) u_pop (
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .lane_mask (lane_mask_s),
    .pop       (pop_s)
  );

  // walk valid lanes as a bit stream, pairing with the carried pending bit
  always_comb begin
    pv_s       = pend_v_q;
    pb_s       = pend_b_q;
    pair_inc_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_mask_s[i]) begin
        if (pv_s) begin
          if (pair_hit(mode_q, pb_s, in_data[i])) begin
            pair_inc_s = pair_inc_s + CW'(1);
          end else begin
            pair_inc_s = pair_inc_s;
          end
          pv_s = 1'b0;
        end else begin
          pv_s = 1'b1;
          pb_s = in_data[i];
        end
      end else begin
        pv_s = pv_s;
      end
    end
  end

  // per-beat increment and saturating add
  always_comb begin
    case (mode_q)
      CM_ALL:         inc_s = pop_s;
      CM_AND, CM_XOR: inc_s = pair_inc_s;
      CM_TWO:         inc_s = (pop_s == CW'(2)) ? CW'(1) : CW'(0);
      default:        inc_s = '0;
    endcase
    sum_s = {1'b0, cand_q} + (CNT_W+1)'(inc_s);
    if (sum_s > CAP) begin
      cand_sat_s = CAP[CNT_W-1:0];
      clip_s     = 1'b1;
    end else begin
      cand_sat_s = sum_s[CNT_W-1:0];
      clip_s     = 1'b0;
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cand_d   = cand_q;
    sat_d    = sat_q;
    pend_v_d = pend_v_q;
    pend_b_d = pend_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACCUM;
          mode_d   = cand_mode_e'(mode);
          cand_d   = '0;
          sat_d    = 1'b0;
          pend_v_d = 1'b0;
          pend_b_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          cand_d = cand_sat_s;
          sat_d  = sat_q | clip_s;
          if (in_last) begin
            // an unpaired trailing bit is dropped, never counted
            state_d  = ST_DONE;
            pend_v_d = 1'b0;
            pend_b_d = 1'b0;
          end else begin
            pend_v_d = pv_s;
            pend_b_d = pb_s;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers; handshake outputs decoded from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= CM_ALL;
      cand_q      <= '0;
      sat_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_b_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cand_q      <= cand_d;
      sat_q       <= sat_d;
      pend_v_q    <= pend_v_d;
      pend_b_q    <= pend_b_d;
      in_ready_q  <= (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign candidate = cand_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_candidate_accumulator.sv
// Directed and randomized bench for candidate_accumulator (LANES=4, CNT_W=4)
// against a stream-level reference model.
module tb_candidate_accumulator;

  localparam int LANES = 4;
  localparam int CNT_W = 4;
  localparam int CAPV  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [LANES-1:0] in_data;
  logic [2:0]       in_cnt;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] candidate;
  logic             sat;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode;
  int m_stream[$];
  int m_pop_total;
  int m_two_total;

  candidate_accumulator #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .candidate (candidate),
    .sat       (sat),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // raw count of hits for the current frame, before saturation
  function automatic int model_total();
    int t;
    t = 0;
    case (m_mode)
      0: t = m_pop_total;
      3: t = m_two_total;
      default: begin
        for (int i = 0; i + 1 < m_stream.size(); i += 2) begin
          if (m_mode == 1) t += (m_stream[i] & m_stream[i+1]);
          else             t += (m_stream[i] ^ m_stream[i+1]);
        end
      end
    endcase
    return t;
  endfunction

  function automatic int exp_cand();
    int t;
    t = model_total();
    return (t > CAPV) ? CAPV : t;
  endfunction

  function automatic int exp_sat();
    return (model_total() > CAPV) ? 1 : 0;
  endfunction

  task automatic check_running(input string tag);
    check_val({tag, ".candidate"}, int'(candidate), exp_cand());
    check_val({tag, ".sat"}, int'(sat), exp_sat());
  endtask

  task automatic begin_count(input int md);
    start = 1'b1;
    mode  = 2'(md);
    @(negedge clk);
    start = 1'b0;
    mode  = 2'(~md);
    m_mode = md;
    m_stream.delete();
    m_pop_total = 0;
    m_two_total = 0;
    check_val("start.busy", int'(busy), 1);
    check_val("start.in_ready", int'(in_ready), 1);
    check_running("start");
  endtask

  task automatic send_beat(input int d, input int c, input bit last);
    int ce;
    int p;
    check_val("beat.in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 4'(d);
    in_cnt   = 3'(c);
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    ce = (c > LANES) ? LANES : c;
    p  = 0;
    for (int i = 0; i < ce; i++) begin
      m_stream.push_back((d >> i) & 1);
      p += (d >> i) & 1;
    end
    m_pop_total += p;
    if (p == 2) m_two_total++;
    check_running("beat");
    check_val("beat.out_valid", int'(out_valid), last ? 1 : 0);
  endtask

  // idle cycles inside a frame; start pulses here must be ignored
  task automatic gap_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      start   = 1'($urandom_range(0, 1));
      mode    = 2'($urandom_range(0, 3));
      in_data = 4'($urandom_range(0, 15));
      in_cnt  = 3'($urandom_range(0, 7));
      @(negedge clk);
      start = 1'b0;
      check_running("gap");
    end
  endtask

  task automatic finish_count(input int hold);
    for (int k = 0; k < hold; k++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
      start = 1'b0;
      check_val("done.out_valid", int'(out_valid), 1);
      check_val("done.in_ready", int'(in_ready), 0);
      check_running("done");
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("idle.out_valid", int'(out_valid), 0);
    check_val("idle.busy", int'(busy), 0);
    check_running("idle");
    @(negedge clk);
    check_running("idle.hold");
  endtask

  initial begin
    int nb;
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 2'b00;
    in_valid  = 1'b0;
    in_data   = 4'b0000;
    in_cnt    = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    m_mode    = 0;
    m_pop_total = 0;
    m_two_total = 0;
    repeat (2) @(negedge clk);
    check_val("rst.candidate", int'(candidate), 0);
    check_val("rst.sat", int'(sat), 0);
    check_val("rst.busy", int'(busy), 0);
    check_val("rst.in_ready", int'(in_ready), 0);
    check_val("rst.out_valid", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // popcount mode
    begin_count(0);
    send_beat(4'b1011, 4, 1'b0);
    send_beat(4'b0111, 3, 1'b1);
    check_val("m00.candidate", int'(candidate), 6);
    finish_count(3);

    // AND pairs with pending bit spanning beats
    begin_count(1);
    send_beat(4'b0111, 3, 1'b0);
    send_beat(4'b0001, 1, 1'b1);
    check_val("m01.candidate", int'(candidate), 2);
    finish_count(1);

    // XOR pairs, trailing bit discarded, empty beat in between
    begin_count(2);
    send_beat(4'b0001, 1, 1'b0);
    send_beat(4'b0000, 0, 1'b0);
    send_beat(4'b0000, 1, 1'b0);
    send_beat(4'b0011, 2, 1'b0);
    send_beat(4'b0001, 1, 1'b1);
    check_val("m10.candidate", int'(candidate), 1);
    finish_count(1);

    // exactly-two mode
    begin_count(3);
    send_beat(4'b0110, 4, 1'b0);
    send_beat(4'b1110, 4, 1'b0);
    send_beat(4'b0011, 2, 1'b1);
    check_val("m11.candidate", int'(candidate), 2);
    finish_count(1);

    // saturation, then start clears it
    begin_count(0);
    for (int i = 0; i < 5; i++) send_beat(4'b1111, 4, i == 4);
    check_val("sat.candidate", int'(candidate), 15);
    check_val("sat.flag", int'(sat), 1);
    finish_count(1);
    begin_count(0);
    check_val("sat.clear", int'(sat), 0);

    // reset in the middle of a frame
    send_beat(4'b0011, 4, 1'b0);
    send_beat(4'b0001, 4, 1'b0);
    rst = 1'b1;
    #1;
    check_val("arst.busy", int'(busy), 0);
    @(negedge clk);
    check_val("arst.candidate", int'(candidate), 0);
    check_val("arst.in_ready", int'(in_ready), 0);
    check_val("arst.out_valid", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("arst.idle_busy", int'(busy), 0);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      begin_count($urandom_range(0, 3));
      nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        gap_cycles($urandom_range(0, 2));
        send_beat($urandom_range(0, 15), $urandom_range(0, 7), b == nb - 1);
      end
      finish_count($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
